// File: rtl/ita_fifo_packer.sv
// ============================================================================
// ita_fifo_packer : holds one requantised vector, streams it as BEATS FIFO words
// Rev 1.0
// ============================================================================
`default_nettype none

module ita_fifo_packer #(
   parameter int N     = 16,
   parameter int WI    = 8,
   parameter int BEATS = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   input  logic [N*WI-1:0]             requant_oup_i,
   input  logic                        activation_done_i,
   output logic                        ready_o,
   input  logic                        fifo_full_i,
   output logic                        push_to_fifo_o,
   output logic [(N/BEATS)*WI-1:0]     data_to_fifo_o,
   output logic                        busy_o,
   output logic                        overflow_o
);

   localparam int EPB = N / BEATS;
   localparam int FW  = EPB * WI;
   localparam int BW  = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   if (N % BEATS != 0) begin : g_beats_check
      $error("ita_fifo_packer: N must be a multiple of BEATS");
   end

   logic [0:0]      r_state;
   logic [0:0]      w_state_nxt;
   logic [BW-1:0]   r_beat;
   logic [BW-1:0]   w_beat_nxt;
   logic [N*WI-1:0] r_hold;
   logic            r_ovf;
   logic            w_push;
   logic            w_ready;
   logic            w_last;
   logic            w_acc;
   logic [FW-1:0]   w_data;

   assign w_last = (r_beat == BW'(BEATS - 1));
   // Clear suppresses the accept, so a strobe in the clear cycle is simply lost.
   assign w_acc  = activation_done_i & w_ready & ~clear_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
         r_hold  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         if (w_acc) begin
            r_hold <= requant_oup_i;
         end
         if (clear_i) begin
            r_ovf <= 1'b0;
         end else if (activation_done_i && !w_ready) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      if (clear_i) begin
         w_state_nxt = S_IDLE;
         w_beat_nxt  = '0;
      end else if (w_acc) begin
         // A new vector landing on the last-beat push takes over without a bubble.
         w_state_nxt = S_SEND;
         w_beat_nxt  = '0;
      end else if (w_push) begin
         if (w_last) begin
            w_state_nxt = S_IDLE;
            w_beat_nxt  = '0;
         end else begin
            w_beat_nxt  = r_beat + BW'(1);
         end
      end
   end

   always_comb begin
      w_push  = (r_state == S_SEND) & ~fifo_full_i & ~clear_i;
      w_ready = (r_state == S_IDLE) | (w_push & w_last);
      w_data  = '0;
      if (w_push) begin
         // Lowest-index element of the beat lands in the most significant slot.
         for (int j = 0; j < EPB; j++) begin
            w_data[(EPB-1-j)*WI +: WI] = r_hold[(int'(r_beat)*EPB + j)*WI +: WI];
         end
      end
   end

   assign push_to_fifo_o = w_push;
   assign ready_o        = w_ready;
   assign data_to_fifo_o = w_data;
   assign busy_o         = (r_state == S_SEND);
   assign overflow_o     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ita_fifo_packer.sv
// ============================================================================
// tb_ita_fifo_packer : two packer configurations against a word-queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ita_fifo_packer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   done, full, clr;
   logic [1:0]   rdy, push, busy, ovf;
   logic [31:0]  vec0;
   logic [127:0] vec1;
   logic [15:0]  dat0;
   logic [127:0] dat1;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: per instance, the words still owed to the FIFO for the held vector.
   int           m_rem [2];
   int           m_nb  [2];
   int           m_n   [2];
   logic [127:0] m_w   [2][2];
   logic         m_ovf [2];

   always #5 clk = ~clk;

   ita_fifo_packer #(.N(4), .WI(8), .BEATS(2)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[0]), .requant_oup_i(vec0),
      .activation_done_i(done[0]), .ready_o(rdy[0]), .fifo_full_i(full[0]),
      .push_to_fifo_o(push[0]), .data_to_fifo_o(dat0), .busy_o(busy[0]),
      .overflow_o(ovf[0])
   );

   ita_fifo_packer #(.N(16), .WI(8), .BEATS(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[1]), .requant_oup_i(vec1),
      .activation_done_i(done[1]), .ready_o(rdy[1]), .fifo_full_i(full[1]),
      .push_to_fifo_o(push[1]), .data_to_fifo_o(dat1), .busy_o(busy[1]),
      .overflow_o(ovf[1])
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Beat b of an n-element byte vector: elements in increasing index, first one on top.
   function automatic logic [127:0] word_of(input logic [127:0] v, input int n,
                                             input int beats, input int b);
      logic [127:0] w;
      int epb;
      w   = '0;
      epb = n / beats;
      for (int j = 0; j < epb; j++) begin
         w = (w << 8) | 128'(v[(b*epb + j)*8 +: 8]);
      end
      return w;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_rem[k] = 0;
         m_ovf[k] = 1'b0;
      end
   endtask

   task automatic check_and_step();
      logic [127:0] obs_d [2];
      logic [127:0] v;
      logic [127:0] e_dat;
      bit e_busy, e_push, e_ready;
      obs_d[0] = 128'(dat0);
      obs_d[1] = dat1;
      for (int k = 0; k < 2; k++) begin
         e_busy  = (m_rem[k] > 0);
         e_push  = e_busy && !full[k] && !clr[k];
         e_ready = !e_busy || (e_push && m_rem[k] == 1);
         e_dat   = '0;
         if (e_push) e_dat = m_w[k][m_nb[k] - m_rem[k]];
         chk($sformatf("push%0d", k),  128'(push[k]), 128'(e_push));
         chk($sformatf("data%0d", k),  obs_d[k], e_dat);
         chk($sformatf("ready%0d", k), 128'(rdy[k]), 128'(e_ready));
         chk($sformatf("busy%0d", k),  128'(busy[k]), 128'(e_busy));
         chk($sformatf("ovf%0d", k),   128'(ovf[k]), 128'(m_ovf[k]));
         if (clr[k]) begin
            m_rem[k] = 0;
            m_ovf[k] = 1'b0;
         end else begin
            if (e_push) m_rem[k]--;
            if (done[k] && e_ready) begin
               v = (k == 0) ? 128'(vec0) : vec1;
               for (int b = 0; b < m_nb[k]; b++) m_w[k][b] = word_of(v, m_n[k], m_nb[k], b);
               m_rem[k] = m_nb[k];
            end else if (done[k]) begin
               m_ovf[k] = 1'b1;
            end
         end
      end
   endtask

   // Inputs are set at posedge+1; outputs are sampled at posedge+2.
   task automatic cyc();
      #1;
      check_and_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic d, input logic [31:0] v, input logic f, input logic c);
      done[0] = d;
      vec0    = v;
      full[0] = f;
      clr[0]  = c;
   endtask

   task automatic reset_outputs_chk(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_ready%0d", tag, k), 128'(rdy[k]), 128'(1'b1));
         chk($sformatf("%s_busy%0d", tag, k),  128'(busy[k]), 128'(1'b0));
         chk($sformatf("%s_push%0d", tag, k),  128'(push[k]), 128'(1'b0));
         chk($sformatf("%s_ovf%0d", tag, k),   128'(ovf[k]), 128'(1'b0));
      end
      chk({tag, "_data0"}, 128'(dat0), 128'(0));
      chk({tag, "_data1"}, dat1, 128'(0));
   endtask

   initial begin
      m_nb[0] = 2; m_n[0] = 4;
      m_nb[1] = 1; m_n[1] = 16;
      model_reset();
      rst_n = 1'b0;
      done = '0; full = '0; clr = '0;
      vec0 = '0; vec1 = '0;

      @(posedge clk);
      #1;
      reset_outputs_chk("rst");
      rst_n = 1'b1;

      // Single vector, no backpressure: 0x1122 then 0x3344.
      set0(1'b1, 32'h44332211, 1'b0, 1'b0); cyc();
      set0(1'b0, 32'h0, 1'b0, 1'b0);        cyc(); cyc(); cyc();

      // Full held for three cycles after accept.
      set0(1'b1, 32'hDDCCBBAA, 1'b0, 1'b0); cyc();
      set0(1'b0, 32'h0, 1'b1, 1'b0);        cyc(); cyc(); cyc();
      set0(1'b0, 32'h0, 1'b0, 1'b0);        cyc(); cyc(); cyc();

      // Back-to-back: B strobed on A's last-beat cycle.
      set0(1'b1, 32'h04030201, 1'b0, 1'b0); cyc();
      set0(1'b0, 32'h0, 1'b0, 1'b0);        cyc();
      set0(1'b1, 32'h08070605, 1'b0, 1'b0); cyc();
      set0(1'b0, 32'h0, 1'b0, 1'b0);        cyc(); cyc(); cyc();

      // Overflow while stalled, sticky, then cleared.
      set0(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0); cyc();
      set0(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0); cyc();
      set0(1'b0, 32'h0, 1'b1, 1'b0);        cyc(); cyc();
      set0(1'b1, 32'h12345678, 1'b0, 1'b1); cyc();
      set0(1'b0, 32'h0, 1'b0, 1'b0);        cyc(); cyc();

      // BEATS=1 instance: one directed vector.
      done[1] = 1'b1;
      vec1    = 128'h0F0E0D0C0B0A09080706050403020100;
      cyc();
      done[1] = 1'b0;
      cyc(); cyc();

      // Asynchronous reset between beats.
      set0(1'b1, 32'hCAFEBABE, 1'b0, 1'b0); cyc();
      set0(1'b0, 32'h0, 1'b0, 1'b0);        cyc();
      full[0] = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      reset_outputs_chk("arst");
      model_reset();
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      full[0] = 1'b0;
      cyc(); cyc();

      // Randomised traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 2; k++) begin
            done[k] = 1'($urandom_range(0, 1));
            full[k] = ($urandom_range(0, 3) == 0);
            clr[k]  = ($urandom_range(0, 15) == 0);
         end
         vec0 = $urandom;
         vec1 = {$urandom, $urandom, $urandom, $urandom};
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ita_fifo_packer.md
Name: ita_fifo_packer

Overview:
Parametrised successor to the requant-to-FIFO push logic. It accepts one requantised output vector of N elements × WI bits per activation_done_i strobe and stores it in a one-entry holding register. It then serialises the vector into BEATS narrower FIFO words and honours fifo_full_i backpressure. It sits between the requantiser/activation stage and the output FIFO, and returns an upstream ready plus a sticky overflow flag.

Parameters:
N, 16, elements per requantised vector
WI, 8, bits per element
BEATS, 2, FIFO words per vector; N % BEATS == 0 required (checked by elaboration assertion); BEATS=1 allowed
EPB, N/BEATS (derived, localparam), elements per beat
FW, EPB*WI (derived, localparam), FIFO word width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear: abandons the held vector and clears overflow_o
requant_oup_i  in  N*WI  requantised vector, element 0 in bits [WI-1:0]
activation_done_i  in  1  input valid strobe; one vector per high cycle
ready_o  out  1  packer can accept a vector this cycle
fifo_full_i  in  1  downstream FIFO full
push_to_fifo_o  out  1  push one word this cycle
data_to_fifo_o  out  FW  word being pushed
busy_o  out  1  holding register occupied
overflow_o  out  1  sticky: strobe arrived while ready_o low

Behaviour:
- Reset (async, rst_ni=0) values:
  - state=IDLE, beat_q=0, holding register=0
  - push_to_fifo_o=0, data_to_fifo_o=0, busy_o=0, overflow_o=0, ready_o=1
- States:
  - IDLE: no vector held.
  - SEND: vector held, beat_q ∈ [0, BEATS-1].
- Accept condition: acc = activation_done_i & ready_o. On acc, the holding register loads requant_oup_i, beat_q becomes 0 and state becomes SEND.
- Push (combinational):
  - push_to_fifo_o = (state==SEND) & ~fifo_full_i & ~clear_i.
  - data_to_fifo_o = held elements [beat_q*EPB .. beat_q*EPB+EPB-1].
  - Within the word, the lowest-index element goes in the MSBs (streaming big-endian order, matching the existing push format).
  - data_to_fifo_o = 0 whenever push_to_fifo_o=0.
- Beat advance:
  - On a push with beat_q<BEATS-1: beat_q increments.
  - On a push with beat_q==BEATS-1 (last beat): state returns to IDLE unless acc occurs in the same cycle.
  - fifo_full_i high: hold state and beat_q; no push. Full may toggle every cycle.
- ready_o = (state==IDLE) | (push_to_fifo_o & beat_q==BEATS-1). This permits back-to-back vectors with zero bubble. The last-beat push and the new load coincide; the new vector wins, state stays SEND and beat_q=0.
- Latency: vector accepted at edge t, first word pushed in cycle t+1 if not full. Steady-state throughput is 1 vector per BEATS cycles.
- Overflow: activation_done_i=1 while ready_o=0 drops the input (register unchanged) and sets overflow_o=1 at the next edge. overflow_o holds until clear_i or reset.
- clear_i (priority over everything except reset):
  - next state=IDLE, beat_q=0, overflow_o=0.
  - No push in the clear cycle.
  - A vector strobed in the clear cycle is dropped and does not set overflow.
- busy_o = (state==SEND).
- Reset mid-vector: remaining beats are lost and no further pushes occur.
- BEATS=1: degenerates to a registered one-cycle push per vector.

Test Plan:
- N=4, WI=8, BEATS=2; strobe vector {e0..e3}={0x11,0x22,0x33,0x44}, fifo_full_i=0 -> cycle+1 push 0x1122, cycle+2 push 0x3344, then busy_o=0.
- Same config, fifo_full_i=1 for 3 cycles after accept -> no push while full; then 0x1122 and 0x3344 pushed on consecutive cycles; no word duplicated or skipped.
- Back-to-back: strobe A at t, B at t+2 (ready_o=1 on last-beat cycle) -> 4 pushes in cycles t+1..t+4, zero bubbles, B's beats follow A's.
- Strobe while ready_o=0 (t+1 after accept, full held) -> input dropped, overflow_o=1 persisting; clear_i pulse -> overflow_o=0, busy_o=0, no push that cycle.
- Assert rst_ni=0 asynchronously mid-SEND between beats -> outputs go to reset values immediately without a clock; after release, ready_o=1 and no stray push.
- BEATS=1, N=16 -> every accepted vector pushed exactly once on the next cycle as one 128-bit word with element 0 in bits [127:120].
